// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the IF stage, IF/ID register and hazard unit.
package cpu_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_INCR  = 32'd4;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        DRAIN,
        HOLD
    } fetch_state_t;

    // Payload handed from IF to the IF/ID register
    typedef struct packed {
        logic [XLEN-1:0] added_pc;
        logic [XLEN-1:0] inst;
    } if_id_t;

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return pc + PC_INCR;
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// IF stage: owns the PC, fetches over a req/ack handshake with one request outstanding,
// applies stalls and branch/jump redirects, and drops fetches made stale by a redirect.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     TIMEOUT  = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            jump_i,
    input  logic [XLEN-1:0] jump_target_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ack_i,
    input  logic [XLEN-1:0] imem_data_i,
    output logic [XLEN-1:0] addedPC_o,
    output logic [XLEN-1:0] inst_o,
    output logic            valid_o,
    output logic            err_o
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    if_id_t          out_q, out_d;
    logic            valid_q, valid_d;
    if_id_t          buf_q, buf_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;

    logic            redirect;
    logic [XLEN-1:0] target;
    logic            ack;
    if_id_t          fetched;

    // Next-state, PC, bus and output-register logic
    always_comb begin
        redirect = branch_i | jump_i;
        target   = branch_i ? branch_target_i : jump_target_i;
        ack      = req_q & imem_ack_i;
        fetched.added_pc = pc_next(addr_q);
        fetched.inst     = imem_data_i;

        state_d = state_q;
        pc_d    = pc_q;
        req_d   = req_q;
        addr_d  = addr_q;
        out_d   = out_q;
        buf_d   = buf_q;
        // Unstalled cycles without a new instruction present a bubble
        valid_d = stall_i ? valid_q : 1'b0;

        case (state_q)
            FETCH, WAIT: begin
                if (redirect) begin
                    out_d   = '{added_pc: '0, inst: NOP_INST};
                    valid_d = 1'b0;
                    buf_d   = '0;
                    pc_d    = target;
                    if (req_q && !imem_ack_i) begin
                        state_d = DRAIN;
                    end else begin
                        req_d   = 1'b1;
                        addr_d  = target;
                        state_d = FETCH;
                    end
                end else if (ack) begin
                    pc_d = fetched.added_pc;
                    if (stall_i) begin
                        buf_d   = fetched;
                        req_d   = 1'b0;
                        state_d = HOLD;
                    end else begin
                        out_d   = fetched;
                        valid_d = 1'b1;
                        req_d   = 1'b1;
                        addr_d  = fetched.added_pc;
                        state_d = FETCH;
                    end
                end else if (req_q) begin
                    state_d = WAIT;
                end else if (!stall_i) begin
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (redirect) begin
                    out_d   = '{added_pc: '0, inst: NOP_INST};
                    valid_d = 1'b0;
                    buf_d   = '0;
                    pc_d    = target;
                end
                // Stale word is dropped; the bus is only released once it has been acked
                if (ack) begin
                    state_d = FETCH;
                    if (redirect || !stall_i) begin
                        req_d  = 1'b1;
                        addr_d = redirect ? target : pc_q;
                    end else begin
                        req_d = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (redirect) begin
                    out_d   = '{added_pc: '0, inst: NOP_INST};
                    valid_d = 1'b0;
                    buf_d   = '0;
                    pc_d    = target;
                    req_d   = 1'b1;
                    addr_d  = target;
                    state_d = FETCH;
                end else if (!stall_i) begin
                    out_d   = buf_q;
                    valid_d = 1'b1;
                    buf_d   = '0;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        tmo_d = tmo_q;
        if (ack) begin
            tmo_d = '0;
        end else if (req_q && (tmo_q != TMO_MAX)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        err_d = err_q | (tmo_d == TMO_MAX);
    end

    // State and register update
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            out_q   <= '0;
            valid_q <= 1'b0;
            buf_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            buf_q   <= buf_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
        end
    end

    assign imem_req_o  = req_q;
    assign imem_addr_o = addr_q;
    assign addedPC_o   = out_q.added_pc;
    assign inst_o      = out_q.inst;
    assign valid_o     = valid_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory model with programmable latency, scoreboard of delivered
// instructions, per-cycle vector table, and hand-written multi-cycle corner cases.
module tb_instr_fetch;

    logic        clk_i;
    logic        rst_i;
    logic        stall_i;
    logic        branch_i;
    logic [31:0] branch_target_i;
    logic        jump_i;
    logic [31:0] jump_target_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic [31:0] added_pc;
    logic [31:0] inst;
    logic        valid;
    logic        err;

    instr_fetch #(.RESET_PC(32'h0), .TIMEOUT(16)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .stall_i         (stall_i),
        .branch_i        (branch_i),
        .branch_target_i (branch_target_i),
        .jump_i          (jump_i),
        .jump_target_i   (jump_target_i),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_ack_i      (mem_ack),
        .imem_data_i     (mem_data),
        .addedPC_o       (added_pc),
        .inst_o          (inst),
        .valid_o         (valid),
        .err_o           (err)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    typedef struct packed {
        logic [31:0] added;
        logic [31:0] inst;
    } exp_t;

    exp_t sb[$];

    int   mem_lat  = 0;
    bit   mem_hang = 1'b0;
    int   mem_cnt  = 0;
    logic req_prev = 1'b0;
    logic [31:0] addr_prev = '0;
    bit   stale    = 1'b0;
    int   tmo      = 0;
    logic err_exp  = 1'b0;
    logic s_rst, s_stall, s_redir;
    exp_t got;

    initial begin
        mem_ack  = 1'b0;
        mem_data = 32'h0;
    end

    // Scoreboard, timeout model and memory model: one ordered step per cycle
    always @(negedge clk_i) begin
        s_rst   = rst_i;
        s_stall = stall_i;
        s_redir = branch_i | jump_i;
        if (s_rst) begin
            sb.delete();
            stale   = 1'b0;
            tmo     = 0;
            err_exp = 1'b0;
        end else begin
            if (s_redir) sb.delete();
            if (req_prev && mem_ack) begin
                if (s_redir || stale) stale = 1'b0;
                else sb.push_back('{added: addr_prev + 32'd4, inst: mem_data});
                tmo = 0;
            end else if (req_prev) begin
                if (s_redir) stale = 1'b1;
                if (tmo < 16) tmo++;
            end
            if (tmo >= 16) err_exp = 1'b1;
            if (!s_stall && valid) begin
                chk("sb_pending", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    got = sb.pop_front();
                    chk("sb_addedpc", added_pc, got.added);
                    chk("sb_inst", inst, got.inst);
                end
            end
            if (req_prev && !mem_ack) begin
                chk("req_held", 32'(imem_req_o), 32'd1);
                chk("addr_held", imem_addr_o, addr_prev);
            end
        end
        chk("err_model", 32'(err), 32'(err_exp));

        req_prev  = imem_req_o;
        addr_prev = imem_addr_o;
        if (!imem_req_o) begin
            mem_ack = 1'b0;
            mem_cnt = 0;
        end else begin
            if (mem_ack) mem_cnt = 0;
            if (!mem_hang && mem_cnt >= mem_lat) begin
                mem_ack  = 1'b1;
                mem_data = mem_word(imem_addr_o);
            end else begin
                mem_ack = 1'b0;
                mem_cnt++;
            end
        end
    end

    task automatic cyc();
        @(negedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i    = 1'b1;
        stall_i  = 1'b0;
        branch_i = 1'b0;
        jump_i   = 1'b0;
        cyc();
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_added", added_pc, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        cyc();
        rst_i = 1'b0;
    endtask

    typedef struct {
        logic        stall;
        logic        branch;
        logic [31:0] btgt;
        logic        jump;
        logic [31:0] jtgt;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_added;
    } vec_t;

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] bt,
                                input logic j, input logic [31:0] jt, input logic er,
                                input logic [31:0] ea, input logic ev, input logic [31:0] ed);
        vec_t v;
        v.stall = s; v.branch = b; v.btgt = bt; v.jump = j; v.jtgt = jt;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_added = ed;
        return v;
    endfunction

    vec_t vecs[17];
    bit   found;
    logic [31:0] exp_inst;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; branch_i = 1'b0; jump_i = 1'b0;
        branch_target_i = '0; jump_target_i = '0;

        // Zero-wait stream, stall at PC 8, branch+jump under stall, jump, wrap, odd target
        vecs[0]  = mk(0, 0, 32'h0,   0, 32'h0,         1, 32'h0,         0, 32'h0);
        vecs[1]  = mk(0, 0, 32'h0,   0, 32'h0,         1, 32'h4,         1, 32'h4);
        vecs[2]  = mk(0, 0, 32'h0,   0, 32'h0,         1, 32'h8,         1, 32'h8);
        vecs[3]  = mk(1, 0, 32'h0,   0, 32'h0,         0, 32'h8,         1, 32'h8);
        vecs[4]  = mk(1, 0, 32'h0,   0, 32'h0,         0, 32'h8,         1, 32'h8);
        vecs[5]  = mk(0, 0, 32'h0,   0, 32'h0,         1, 32'hC,         1, 32'hC);
        vecs[6]  = mk(0, 0, 32'h0,   0, 32'h0,         1, 32'h10,        1, 32'h10);
        vecs[7]  = mk(1, 1, 32'h40,  1, 32'h80,        1, 32'h40,        0, 32'h0);
        vecs[8]  = mk(1, 0, 32'h0,   0, 32'h0,         0, 32'h40,        0, 32'h0);
        vecs[9]  = mk(0, 0, 32'h0,   0, 32'h0,         1, 32'h44,        1, 32'h44);
        vecs[10] = mk(0, 0, 32'h0,   1, 32'h80,        1, 32'h80,        0, 32'h0);
        vecs[11] = mk(0, 0, 32'h0,   0, 32'h0,         1, 32'h84,        1, 32'h84);
        vecs[12] = mk(0, 0, 32'h0,   1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 32'h0);
        vecs[13] = mk(0, 0, 32'h0,   0, 32'h0,         1, 32'h0,         1, 32'h0);
        vecs[14] = mk(0, 0, 32'h0,   0, 32'h0,         1, 32'h4,         1, 32'h4);
        vecs[15] = mk(0, 1, 32'h103, 0, 32'h0,         1, 32'h103,       0, 32'h0);
        vecs[16] = mk(0, 0, 32'h0,   0, 32'h0,         1, 32'h107,       1, 32'h107);

        mem_lat = 0;
        mem_hang = 1'b0;
        do_reset();
        foreach (vecs[i]) begin
            stall_i         = vecs[i].stall;
            branch_i        = vecs[i].branch;
            branch_target_i = vecs[i].btgt;
            jump_i          = vecs[i].jump;
            jump_target_i   = vecs[i].jtgt;
            cyc();
            exp_inst = vecs[i].exp_valid ? mem_word(vecs[i].exp_added - 32'd4) : 32'h0;
            chk($sformatf("v%0d_req", i), 32'(imem_req_o), 32'(vecs[i].exp_req));
            chk($sformatf("v%0d_addr", i), imem_addr_o, vecs[i].exp_addr);
            chk($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].exp_valid));
            chk($sformatf("v%0d_added", i), added_pc, vecs[i].exp_added);
            chk($sformatf("v%0d_inst", i), inst, exp_inst);
        end
        stall_i = 1'b0; branch_i = 1'b0; jump_i = 1'b0;

        // Ack three cycles late: address held, valid only the cycle after the ack
        mem_lat = 3;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("late_req", 32'(imem_req_o), 32'd1);
            chk("late_addr", imem_addr_o, 32'h0);
            chk("late_valid", 32'(valid), 32'd0);
        end
        cyc();
        chk("late_ackcyc_valid", 32'(valid), 32'd0);
        cyc();
        chk("late_valid_after", 32'(valid), 32'd1);
        chk("late_added", added_pc, 32'h4);
        chk("late_inst", inst, mem_word(32'h0));
        cyc();
        chk("late_bubble", 32'(valid), 32'd0);

        // Branch during WAIT on 0x10: stale ack dropped, next request at 0x100
        mem_lat = 2;
        do_reset();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cyc();
            if (imem_req_o && imem_addr_o == 32'h10) found = 1'b1;
        end
        chk("drain_reach_0x10", 32'(found), 32'd1);
        branch_i = 1'b1;
        branch_target_i = 32'h100;
        cyc();
        branch_i = 1'b0;
        chk("drain_valid", 32'(valid), 32'd0);
        chk("drain_added", added_pc, 32'h0);
        chk("drain_addr", imem_addr_o, 32'h10);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            cyc();
            if (imem_addr_o != 32'h10) found = 1'b1;
        end
        chk("drain_moved", 32'(found), 32'd1);
        chk("drain_next_addr", imem_addr_o, 32'h100);
        chk("drain_next_req", 32'(imem_req_o), 32'd1);
        repeat (8) cyc();
        mem_hang = 1'b1;
        repeat (3) cyc();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        // Timeout: err sets after 16 un-acked cycles, sticks through a late ack
        mem_lat = 0;
        mem_hang = 1'b1;
        do_reset();
        repeat (10) cyc();
        chk("tmo_early", 32'(err), 32'd0);
        repeat (10) cyc();
        chk("tmo_set", 32'(err), 32'd1);
        chk("tmo_addr", imem_addr_o, 32'h0);
        mem_hang = 1'b0;
        repeat (4) cyc();
        chk("tmo_sticky", 32'(err), 32'd1);
        chk("tmo_fetch_resumed", 32'(valid), 32'd1);
        do_reset();
        cyc();
        chk("tmo_cleared", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
